// File: rtl/icap_wr_ctrl_if.sv
// Handshake and ICAP-side signal bundle for icap_wr_ctrl.
// The master drives burst control and bitstream data; the slave is the controller.
interface icap_wr_ctrl_if #(
    parameter int CNT_W = 24
);
    logic             start;
    logic [CNT_W-1:0] size;
    logic             abort;
    logic [31:0]      in_data;
    logic             in_valid;
    logic             in_ready;
    logic             icap_csib;
    logic             icap_rdwrb;
    logic [31:0]      icap_i;
    logic             busy;
    logic             done;
    logic             aborted;
    logic [CNT_W-1:0] words_written;

    modport master (
        output start, size, abort, in_data, in_valid,
        input  in_ready, icap_csib, icap_rdwrb, icap_i, busy, done, aborted, words_written
    );

    modport slave (
        input  start, size, abort, in_data, in_valid,
        output in_ready, icap_csib, icap_rdwrb, icap_i, busy, done, aborted, words_written
    );
endinterface

// File: rtl/icap_wr_ctrl.sv
// Streams a counted burst of 32-bit bitstream words into a 7-series ICAP write port.
// clk also clocks the ICAP primitive, so every ICAP-facing output is registered.
module icap_wr_ctrl #(
    parameter int CNT_W     = 24,
    parameter int SWAP_BITS = 1
) (
    input  logic           clk,
    input  logic           rst,
    icap_wr_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        FLUSH,
        DONE
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] remaining_q;
    logic [CNT_W-1:0] remaining_d;
    logic [CNT_W-1:0] words_written_q;
    logic [CNT_W-1:0] words_written_d;
    logic             icap_csib_q;
    logic [31:0]      icap_i_q;
    logic             done_q;
    logic             aborted_q;
    logic [31:0]      swapped;
    logic             in_ready;
    logic             handshake;

    // ICAP expects the bits of every byte in reverse order relative to the bitstream file.
    genvar gi;
    generate
        if (SWAP_BITS != 0) begin : g_swap
            for (gi = 0; gi < 32; gi++) begin : g_bit
                assign swapped[(gi / 8) * 8 + 7 - (gi % 8)] = bus.in_data[gi];
            end
        end else begin : g_noswap
            assign swapped = bus.in_data;
        end
    endgenerate

    assign in_ready        = (state_q == WRITE) && (remaining_q != '0) && !bus.abort;
    assign handshake       = in_ready && bus.in_valid;
    assign remaining_d     = remaining_q - 1'b1;
    assign words_written_d = words_written_q + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            remaining_q     <= '0;
            words_written_q <= '0;
            icap_csib_q     <= 1'b1;
            icap_i_q        <= '0;
            done_q          <= 1'b0;
            aborted_q       <= 1'b0;
        end else begin
            // Pulses and the ICAP enable default to inactive; icap_i holds its last word.
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
            icap_csib_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        remaining_q     <= bus.size;
                        words_written_q <= '0;
                        if (bus.size == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    if (bus.abort) begin
                        aborted_q <= 1'b1;
                        state_q   <= IDLE;
                    end else if (handshake) begin
                        icap_csib_q     <= 1'b0;
                        icap_i_q        <= swapped;
                        remaining_q     <= remaining_d;
                        words_written_q <= words_written_d;
                        if (remaining_q == CNT_W'(1)) begin
                            state_q <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    state_q <= DONE;
                    done_q  <= 1'b1;
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready      = in_ready;
    assign bus.icap_csib     = icap_csib_q;
    assign bus.icap_rdwrb    = 1'b0;
    assign bus.icap_i        = icap_i_q;
    assign bus.busy          = (state_q != IDLE);
    assign bus.done          = done_q;
    assign bus.aborted       = aborted_q;
    assign bus.words_written = words_written_q;
endmodule
